// File: rtl/cp0_ext_pkg.sv
// CP0 register addresses, exception codes and register bit positions shared by
// the CP0 block, its bus interface and its timer.
package cp0_ext_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CODE_W = 5;

  localparam logic [ADDR_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [ADDR_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [ADDR_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [ADDR_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC      = 5'd14;
  localparam logic [ADDR_W-1:0] CP0_PRID     = 5'd15;

  localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;

  localparam logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC0_0380;

  // Address-error exceptions are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [CODE_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_ext_if.sv
// MTC0/MFC0 and exception/ERET bus between the pipeline (master) and CP0 (slave).
interface cp0_ext_if;
  import cp0_ext_pkg::*;

  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [ADDR_W-1:0] raddr_i;
  logic [DATA_W-1:0] data_o;
  logic              exc_valid_i;
  logic [CODE_W-1:0] execode_i;
  logic [DATA_W-1:0] exc_pc_i;
  logic              exc_bd_i;
  logic [DATA_W-1:0] exc_badvaddr_i;
  logic              eret_i;
  logic [DATA_W-1:0] exc_vector_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i,
    output exc_valid_i, execode_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    input  data_o, exc_vector_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i,
    input  exc_valid_i, execode_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    output data_o, exc_vector_o
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with clock divider and sticky timer interrupt (TI).
// Only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
  import cp0_ext_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_we_i,
  input  logic              compare_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] compare_o,
  output logic              ti_o
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic              ti_q, ti_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  // Match is seen on the registered values, so TI rises the cycle after Count==Compare.
  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = '0;
    end else if (div_q == DIV_W'(COUNT_DIV - 1)) begin
      count_d = count_q + 32'd1;
      div_d   = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule
`endif

// File: rtl/cp0_ext.sv
// MIPS-style CP0: Status/Cause/EPC/BadVAddr/PRId, exception entry/ERET and interrupt request.
// Define CP0_TIMER_EN to build in the Count/Compare timer (cp0_timer).
module cp0_ext
  import cp0_ext_pkg::*;
#(
  parameter int unsigned HW_INT_NUM = 6,
  parameter int unsigned COUNT_DIV  = 1,
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] int_i,
  cp0_ext_if.slave              bus,
  output logic [DATA_W-1:0]     status_o,
  output logic [DATA_W-1:0]     cause_o,
  output logic [DATA_W-1:0]     epc_o,
  output logic [DATA_W-1:0]     count_o,
  output logic [DATA_W-1:0]     compare_o,
  output logic                  int_req_o
);

  localparam bit PARAMS_OK = (HW_INT_NUM >= 1) && (HW_INT_NUM <= 6) &&
                             (COUNT_DIV >= 1) && (COUNT_DIV <= 16);

  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d, ie_q, ie_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [HW_INT_NUM-1:0] ip_hw_q, ip_hw_d;
  logic [DATA_W-1:0]     epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic                  bd_q, bd_d;
  logic [CODE_W-1:0]     exccode_q, exccode_d;
  logic                  status_we, cause_we, epc_we, ti;
  logic [5:0]            hw_ext;
  logic [7:0]            ip;
  logic [DATA_W-1:0]     count, compare;
  logic                  unused_params;

  assign unused_params = PARAMS_OK;
  assign status_we     = bus.we_i && (bus.waddr_i == CP0_STATUS);
  assign cause_we      = bus.we_i && (bus.waddr_i == CP0_CAUSE);
  assign epc_we        = bus.we_i && (bus.waddr_i == CP0_EPC);

`ifdef CP0_TIMER_EN
  logic count_we, compare_we;
  assign count_we   = bus.we_i && (bus.waddr_i == CP0_COUNT);
  assign compare_we = bus.we_i && (bus.waddr_i == CP0_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .wdata_i      (bus.wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
    end
  end

  // Software writes first; exception/ERET then override only the fields they own.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = int_i;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    if (status_we) begin
      im_d  = bus.wdata_i[15:8];
      exl_d = bus.wdata_i[STATUS_EXL];
      ie_d  = bus.wdata_i[STATUS_IE];
    end
    if (cause_we) ip_sw_d = bus.wdata_i[9:8];
    if (epc_we)   epc_d   = bus.wdata_i;
    if (bus.exc_valid_i) begin
      exccode_d = bus.execode_i;
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
        bd_d  = bus.exc_bd_i;
      end
      if (is_addr_exc(bus.execode_i)) badvaddr_d = bus.exc_badvaddr_i;
    end else if (bus.eret_i) begin
      exl_d = 1'b0;
    end
  end

  // IP7 is shared between the timer and the sixth hardware line.
  assign hw_ext    = 6'(ip_hw_q);
  assign ip        = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};
  assign status_o  = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_o   = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};
  assign epc_o     = epc_q;
  assign count_o   = count;
  assign compare_o = compare;
  assign int_req_o = ie_q & ~exl_q & (|(im_q & ip));

  assign bus.exc_vector_o = bus.exc_valid_i ? EXC_VECTOR :
                            bus.eret_i      ? epc_q      : '0;

  always_comb begin
    bus.data_o = '0;
    case (bus.raddr_i)
      CP0_BADVADDR: bus.data_o = badvaddr_q;
      CP0_COUNT:    bus.data_o = count;
      CP0_COMPARE:  bus.data_o = compare;
      CP0_STATUS:   bus.data_o = status_o;
      CP0_CAUSE:    bus.data_o = cause_o;
      CP0_EPC:      bus.data_o = epc_q;
      CP0_PRID:     bus.data_o = PRID_VAL;
      default:      bus.data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
// Directed bench for cp0_ext: word-level CP0 model checked every cycle plus literal checkpoints.
module tb_cp0_ext;

  localparam int unsigned HW  = 6;
  localparam int unsigned DIV = 1;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [HW-1:0] int_i = '0;
  logic [31:0]   status_o, cause_o, epc_o, count_o, compare_o;
  logic          int_req_o;

  cp0_ext_if bus();

  cp0_ext #(.HW_INT_NUM(HW), .COUNT_DIV(DIV), .PRID_VAL(32'h0000_4220)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .bus(bus),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .count_o(count_o), .compare_o(compare_o), .int_req_o(int_req_o)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural state held as whole words / plain counters.
  typedef struct packed {
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] since;
    logic [1:0]  ipsw;
    logic [5:0]  hw;
    logic        bd;
    logic        ti;
    logic [4:0]  code;
  } m_t;

  m_t m;

  function automatic m_t m_reset();
    m_t r = '0;
    r.status = 32'h0040_0000;
    return r;
  endfunction

  function automatic logic [31:0] m_cause(input m_t s);
    return (32'(s.bd) << 31) | (32'(s.ti) << 30) | (32'(s.hw) << 10) |
           (32'(s.ti) << 15) | (32'(s.ipsw) << 8) | (32'(s.code) << 2);
  endfunction

  function automatic logic m_int(input m_t s);
    logic [31:0] c = m_cause(s);
    return s.status[0] && !s.status[1] && ((s.status[15:8] & c[15:8]) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input m_t s, input logic [4:0] a);
    case (a)
      5'd8:    return s.bad;
      5'd9:    return s.count;
      5'd11:   return s.compare;
      5'd12:   return s.status;
      5'd13:   return m_cause(s);
      5'd14:   return s.epc;
      5'd15:   return 32'h0000_4220;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_vec(input m_t s);
    if (bus.exc_valid_i) return 32'hBFC0_0380;
    if (bus.eret_i)      return s.epc;
    return 32'h0;
  endfunction

  function automatic m_t m_step(input m_t s);
    m_t n = s;
    logic wr = bus.we_i;
    n.hw = 6'(int_i);
    if (TIMER) begin
      n.ti = s.ti || (s.count == s.compare);
      if (wr && bus.waddr_i == 5'd9) begin
        n.count = bus.wdata_i;
        n.since = 0;
      end else begin
        n.since = s.since + 1;
        if ((n.since % DIV) == 0) n.count = s.count + 1;
      end
      if (wr && bus.waddr_i == 5'd11) begin
        n.compare = bus.wdata_i;
        n.ti      = 1'b0;
      end
    end
    if (wr && bus.waddr_i == 5'd12) n.status = (s.status & ~32'h0000_FF03) | (bus.wdata_i & 32'h0000_FF03);
    if (wr && bus.waddr_i == 5'd13) n.ipsw = bus.wdata_i[9:8];
    if (wr && bus.waddr_i == 5'd14) n.epc = bus.wdata_i;
    if (bus.exc_valid_i) begin
      n.code      = bus.execode_i;
      n.status[1] = 1'b1;
      if (!s.status[1]) begin
        n.epc = bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
        n.bd  = bus.exc_bd_i;
      end
      if (bus.execode_i == 5'd4 || bus.execode_i == 5'd5) n.bad = bus.exc_badvaddr_i;
    end else if (bus.eret_i) begin
      n.status[1] = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= m_reset();
    else      m <= m_step(m);
  end

  always @(negedge clk) begin
    check("status", status_o, m.status);
    check("cause", cause_o, m_cause(m));
    check("epc", epc_o, m.epc);
    check("count", count_o, m.count);
    check("compare", compare_o, m.compare);
    check("int_req", 32'(int_req_o), 32'(m_int(m)));
    check("data_o", bus.data_o, m_read(m, bus.raddr_i));
    check("vector", bus.exc_vector_o, m_vec(m));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
    tick(1);
    bus.we_i = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic [31:0] bv);
    bus.exc_valid_i = 1'b1; bus.execode_i = code; bus.exc_pc_i = pc;
    bus.exc_bd_i = bd; bus.exc_badvaddr_i = bv;
  endtask

  initial begin
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
    bus.exc_valid_i = 1'b0; bus.execode_i = '0; bus.exc_pc_i = '0;
    bus.exc_bd_i = 1'b0; bus.exc_badvaddr_i = '0; bus.eret_i = 1'b0;
    tick(1);
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_int", 32'(int_req_o), 32'h0);
    tick(1);
    rst = 1'b1;

    // Timer: Compare=20 then Count=0, TI must appear 22 cycles after the Compare write.
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    tick(20);
    check("cnt_c21", count_o, TIMER ? 32'd20 : 32'd0);
    check("ti_c21", 32'(cause_o[30]), 32'h0);
    tick(1);
    check("ti_c22", 32'(cause_o[30]), 32'(TIMER));
    check("ip7_c22", 32'(cause_o[15]), 32'(TIMER));
    mtc0(5'd11, 32'h1000);
    check("ti_clr", 32'(cause_o[30]), 32'h0);
    check("cnt_c23", count_o, TIMER ? 32'd22 : 32'd0);

    // Interrupt request through IM2 and its masking by EXL.
    mtc0(5'd12, 32'h0000_0401);
    int_i = 6'b000001;
    #1 check("int_early", 32'(int_req_o), 32'h0);
    tick(1);
    check("int_set", 32'(int_req_o), 32'h1);
    mtc0(5'd12, 32'h0000_0403);
    check("int_exl", 32'(int_req_o), 32'h0);
    mtc0(5'd12, 32'h0);
    int_i = '0;

    // Read-only fields and read port behaviour.
    mtc0(5'd12, 32'hFFFF_FFFF);
    check("status_ro", status_o, 32'h0040_FF03);
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_ro", cause_o, 32'h0000_0300);
    mtc0(5'd13, 32'h0);
    mtc0(5'd15, 32'hFFFF_FFFF);
    bus.raddr_i = 5'd15;
    #1 check("prid", bus.data_o, 32'h0000_4220);
    bus.raddr_i = 5'd3;
    #1 check("unimpl", bus.data_o, 32'h0);
    tick(1);
    bus.raddr_i = 5'd14;
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1234;
    #1 check("rd_old", bus.data_o, 32'h0);
    tick(1);
    bus.we_i = 1'b0;
    check("rd_new", bus.data_o, 32'h1234);

    // Address-error exception in a delay slot.
    exc(5'd4, 32'h100, 1'b1, 32'h3);
    #1 check("vec_exc", bus.exc_vector_o, 32'hBFC0_0380);
    tick(1);
    bus.exc_valid_i = 1'b0;
    bus.raddr_i = 5'd8;
    check("epc_bd", epc_o, 32'h0000_00FC);
    check("bd", 32'(cause_o[31]), 32'h1);
    check("code4", 32'(cause_o[6:2]), 32'd4);
    check("exl_set", 32'(status_o[1]), 32'h1);
    #1 check("badvaddr", bus.data_o, 32'h3);

    // Nested exception keeps EPC/BD, ERET returns to EPC.
    tick(1);
    exc(5'd12, 32'h200, 1'b0, 32'h777);
    tick(1);
    bus.exc_valid_i = 1'b0;
    check("epc_keep", epc_o, 32'h0000_00FC);
    check("code12", 32'(cause_o[6:2]), 32'd12);
    check("bd_keep", 32'(cause_o[31]), 32'h1);
    check("bad_keep", bus.data_o, 32'h3);
    bus.eret_i = 1'b1;
    #1 check("vec_eret", bus.exc_vector_o, 32'h0000_00FC);
    tick(1);
    bus.eret_i = 1'b0;
    check("exl_clr", 32'(status_o[1]), 32'h0);

    // Exception overrides a same-cycle MTC0 to EPC.
    exc(5'd0, 32'h80, 1'b0, 32'h0);
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h55;
    tick(1);
    bus.exc_valid_i = 1'b0; bus.we_i = 1'b0;
    check("epc_win", epc_o, 32'h80);
    bus.eret_i = 1'b1;
    tick(1);
    bus.eret_i = 1'b0;

    // Same-cycle MTC0 Status: IM/IE land, EXL still forced by the exception.
    exc(5'd10, 32'h300, 1'b0, 32'h0);
    bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'h0000_0401;
    tick(1);
    bus.exc_valid_i = 1'b0; bus.we_i = 1'b0;
    check("status_mix", status_o, 32'h0040_0403);
    bus.eret_i = 1'b1;
    tick(1);
    bus.eret_i = 1'b0;

    // Exception beats ERET in the same cycle.
    exc(5'd8, 32'h400, 1'b0, 32'h0);
    bus.eret_i = 1'b1;
    tick(1);
    bus.exc_valid_i = 1'b0; bus.eret_i = 1'b0;
    check("exc_over_eret", 32'(status_o[1]), 32'h1);
    check("epc_400", epc_o, 32'h400);
    bus.eret_i = 1'b1;
    tick(1);
    bus.eret_i = 1'b0;

    // Asynchronous reset in the middle of counting.
    mtc0(5'd9, 32'h1234);
    mtc0(5'd12, 32'h0000_0401);
    int_i = 6'b000001;
    tick(2);
    check("pre_rst_int", 32'(int_req_o), 32'h1);
    check("pre_rst_cnt", count_o, TIMER ? 32'h1237 : 32'h0);
    rst = 1'b0;
    #1;
    check("arst_status", status_o, 32'h0040_0000);
    check("arst_cause", cause_o, 32'h0);
    check("arst_epc", epc_o, 32'h0);
    check("arst_count", count_o, 32'h0);
    check("arst_compare", compare_o, 32'h0);
    check("arst_int", 32'(int_req_o), 32'h0);
    check("arst_bad", bus.data_o, 32'h0);
    int_i = '0;
    tick(2);
    rst = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
